cb_skew_pipe: RTL and testbench

Synthesizable, parametrised clocking-block engine with cycle-granular, runtime-programmable input and output skews across multiple channels. Input sampling looks back a configurable number of cycles. Drive requests are applied a configurable number of cycles later. Skews can be reconfigured safely while traffic is in flight. It sits between a DUT register stage and the bench or sequencer side, so multi-cycle skew behaviour exists in RTL rather than only in testbench clocking blocks.

---
 rtl/cb_skew_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_cb_skew_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cb_skew_pipe.sv
// cb_skew_pipe
//   Cycle-granular clocking-block engine. It is placed between a DUT register
//   stage and the bench/sequencer side. Inputs are sampled with a
//   programmable look-back. Drive requests are applied after a programmable
//   delay. The output skew is changed only once the drive slots have drained,
//   so that requests already in flight never collide with new ones.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   q_i             raw signals to sample, channel c at [c*WIDTH +: WIDTH]
//   cb_q_o          sample taken in_skew_o edges ago
//   cb_q_valid_o    history is deep enough for the current input skew
//   d_i, d_valid_i  per-channel drive data and request
//   d_ready_o       requests are accepted this cycle
//   d_o             driven outputs; each holds its value between updates
//   cfg_we_i        skew reconfiguration pulse with in_skew_i / out_skew_i
//   cfg_busy_o      reconfiguration waiting for the drive slots to drain
//   in_skew_o,
//   out_skew_o      skews currently in effect
module cb_skew_pipe #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 2,
    parameter int MAX_IN_SKEW  = 3,
    parameter int MAX_OUT_SKEW = 4,
    parameter int IN_SKEW_RST  = 3,
    parameter int OUT_SKEW_RST = 2,
    // Derived width of the skew fields; do not override.
    parameter int SW = $clog2(((MAX_IN_SKEW > MAX_OUT_SKEW) ? MAX_IN_SKEW : MAX_OUT_SKEW) + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] q_i,
    output logic [CHANNELS*WIDTH-1:0] cb_q_o,
    output logic                      cb_q_valid_o,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    input  logic [CHANNELS-1:0]       d_valid_i,
    output logic                      d_ready_o,
    output logic [CHANNELS*WIDTH-1:0] d_o,
    input  logic                      cfg_we_i,
    input  logic [SW-1:0]             in_skew_i,
    input  logic [SW-1:0]             out_skew_i,
    output logic                      cfg_busy_o,
    output logic [SW-1:0]             in_skew_o,
    output logic [SW-1:0]             out_skew_o
);

    localparam int FW = $clog2(MAX_IN_SKEW + 2);
    localparam logic [FW-1:0] FILL_MAX = FW'(MAX_IN_SKEW + 1);
    localparam logic [SW-1:0] IN_RST_C  = SW'((IN_SKEW_RST  > MAX_IN_SKEW)  ? MAX_IN_SKEW  : IN_SKEW_RST);
    localparam logic [SW-1:0] OUT_RST_C = SW'((OUT_SKEW_RST > MAX_OUT_SKEW) ? MAX_OUT_SKEW : OUT_SKEW_RST);

    typedef enum logic {RUN, DRAIN} state_t;

    function automatic logic [SW-1:0] clamp_skew(input logic [SW-1:0] s, input int max_v);
        if (int'(s) > max_v) return SW'(max_v);
        return s;
    endfunction

    logic [WIDTH-1:0]        r_hist   [CHANNELS][MAX_IN_SKEW+1];
    logic [FW-1:0]           r_fill;
    logic [WIDTH-1:0]        r_slot_d [CHANNELS][MAX_OUT_SKEW];
    logic [MAX_OUT_SKEW-1:0] r_slot_v [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_d_o;
    state_t                  r_state;
    logic                    r_d_ready;
    logic                    r_cfg_busy;
    logic [SW-1:0]           r_in_skew, r_out_skew;
    logic [SW-1:0]           r_pend_in, r_pend_out;

    // Slot MAX_OUT_SKEW is never stored. Only a request with the maximum
    // skew enters it, and every slot is shifted down in the same cycle.
    logic [WIDTH-1:0]        w_stage_d [CHANNELS][MAX_OUT_SKEW+1];
    logic [MAX_OUT_SKEW:0]   w_stage_v [CHANNELS];
    logic [WIDTH-1:0]        w_next_d  [CHANNELS][MAX_OUT_SKEW];
    logic [MAX_OUT_SKEW-1:0] w_next_v  [CHANNELS];
    logic                    w_next_empty;
    logic                    w_collide;

    // Input history and look-back select
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k <= MAX_IN_SKEW; k++)
                    r_hist[c][k] <= '0;
            r_fill <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_hist[c][0] <= q_i[c*WIDTH +: WIDTH];
                for (int k = 1; k <= MAX_IN_SKEW; k++)
                    r_hist[c][k] <= r_hist[c][k-1];
            end
            if (r_fill != FILL_MAX)
                r_fill <= r_fill + FW'(1);
        end
    end

    always_comb begin
        cb_q_o = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k <= MAX_IN_SKEW; k++)
                if (int'(r_in_skew) == k)
                    cb_q_o[c*WIDTH +: WIDTH] = r_hist[c][k];
    end

    assign cb_q_valid_o = (int'(r_fill) > int'(r_in_skew));

    // Drive slots. A request is inserted at index out_skew before the shift,
    // so that it reaches d_o exactly out_skew edges after acceptance.
    always_comb begin
        w_next_empty = 1'b1;
        w_collide    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_stage_v[c] = '0;
            for (int k = 0; k < MAX_OUT_SKEW; k++) begin
                w_stage_d[c][k] = r_slot_d[c][k];
                w_stage_v[c][k] = r_slot_v[c][k];
            end
            w_stage_d[c][MAX_OUT_SKEW] = '0;
            if (r_d_ready && d_valid_i[c]) begin
                for (int k = 0; k <= MAX_OUT_SKEW; k++) begin
                    if (int'(r_out_skew) == k) begin
                        if (w_stage_v[c][k]) w_collide = 1'b1;
                        w_stage_d[c][k] = d_i[c*WIDTH +: WIDTH];
                        w_stage_v[c][k] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < MAX_OUT_SKEW; k++) begin
                w_next_d[c][k] = w_stage_d[c][k+1];
                w_next_v[c][k] = w_stage_v[c][k+1];
            end
            if (w_next_v[c] != '0) w_next_empty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_slot_v[c] <= '0;
                for (int k = 0; k < MAX_OUT_SKEW; k++)
                    r_slot_d[c][k] <= '0;
            end
            r_d_o <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_slot_v[c] <= w_next_v[c];
                for (int k = 0; k < MAX_OUT_SKEW; k++)
                    r_slot_d[c][k] <= w_next_d[c][k];
                if (w_stage_v[c][0])
                    r_d_o[c*WIDTH +: WIDTH] <= w_stage_d[c][0];
            end
        end
    end

    // Control FSM: skews change only when no drive request is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_d_ready  <= 1'b1;
            r_cfg_busy <= 1'b0;
            r_in_skew  <= IN_RST_C;
            r_out_skew <= OUT_RST_C;
            r_pend_in  <= IN_RST_C;
            r_pend_out <= OUT_RST_C;
        end else begin
            case (r_state)
                RUN: begin
                    if (cfg_we_i) begin
                        if (w_next_empty) begin
                            r_in_skew  <= clamp_skew(in_skew_i, MAX_IN_SKEW);
                            r_out_skew <= clamp_skew(out_skew_i, MAX_OUT_SKEW);
                        end else begin
                            r_pend_in  <= clamp_skew(in_skew_i, MAX_IN_SKEW);
                            r_pend_out <= clamp_skew(out_skew_i, MAX_OUT_SKEW);
                            r_state    <= DRAIN;
                            r_d_ready  <= 1'b0;
                            r_cfg_busy <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_next_empty) begin
                        // A write on the exit edge is the most recent one and wins.
                        r_in_skew  <= cfg_we_i ? clamp_skew(in_skew_i, MAX_IN_SKEW)   : r_pend_in;
                        r_out_skew <= cfg_we_i ? clamp_skew(out_skew_i, MAX_OUT_SKEW) : r_pend_out;
                        r_state    <= RUN;
                        r_d_ready  <= 1'b1;
                        r_cfg_busy <= 1'b0;
                    end else if (cfg_we_i) begin
                        r_pend_in  <= clamp_skew(in_skew_i, MAX_IN_SKEW);
                        r_pend_out <= clamp_skew(out_skew_i, MAX_OUT_SKEW);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!w_collide);
    end

    assign d_o        = r_d_o;
    assign d_ready_o  = r_d_ready;
    assign cfg_busy_o = r_cfg_busy;
    assign in_skew_o  = r_in_skew;
    assign out_skew_o = r_out_skew;

endmodule

// File: tb/tb_cb_skew_pipe.sv
module tb_cb_skew_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] q_i;
    logic [15:0] cb_q_o;
    logic        cb_q_valid_o;
    logic [15:0] d_i;
    logic [1:0]  d_valid_i;
    logic        d_ready_o;
    logic [15:0] d_o;
    logic        cfg_we_i;
    logic [2:0]  in_skew_i;
    logic [2:0]  out_skew_i;
    logic        cfg_busy_o;
    logic [2:0]  in_skew_o;
    logic [2:0]  out_skew_o;

    int tests;
    int fails;

    cb_skew_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .q_i          (q_i),
        .cb_q_o       (cb_q_o),
        .cb_q_valid_o (cb_q_valid_o),
        .d_i          (d_i),
        .d_valid_i    (d_valid_i),
        .d_ready_o    (d_ready_o),
        .d_o          (d_o),
        .cfg_we_i     (cfg_we_i),
        .in_skew_i    (in_skew_i),
        .out_skew_i   (out_skew_i),
        .cfg_busy_o   (cfg_busy_o),
        .in_skew_o    (in_skew_o),
        .out_skew_o   (out_skew_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q0, q1, d0, d1;
        logic [1:0] dv;
        logic [7:0] e_cb0, e_cb1;
        logic       e_vld;
        logic [7:0] e_d0, e_d1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q_i        = '0;
        d_i        = '0;
        d_valid_i  = '0;
        cfg_we_i   = 1'b0;
        in_skew_i  = 3'd0;
        out_skew_i = 3'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle();

        // Ramp on ch0 at in skew 3, drive 02/04/08 on ch0 at out skew 2, ch1 request later
        vecs[0] = '{8'h01, 8'hA1, 8'h00, 8'hFF, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{8'h02, 8'hA2, 8'h02, 8'hFF, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{8'h04, 8'hA3, 8'h04, 8'hFF, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'h08, 8'hA4, 8'h08, 8'hFF, 2'b01, 8'h01, 8'hA1, 1'b1, 8'h02, 8'h00};
        vecs[4] = '{8'h10, 8'hA5, 8'h00, 8'hFF, 2'b00, 8'h02, 8'hA2, 1'b1, 8'h04, 8'h00};
        vecs[5] = '{8'h20, 8'hA6, 8'h00, 8'hFF, 2'b00, 8'h04, 8'hA3, 1'b1, 8'h08, 8'h00};
        vecs[6] = '{8'h40, 8'hA7, 8'h00, 8'h5A, 2'b10, 8'h08, 8'hA4, 1'b1, 8'h08, 8'h00};
        vecs[7] = '{8'h80, 8'hA8, 8'h00, 8'h00, 2'b00, 8'h10, 8'hA5, 1'b1, 8'h08, 8'h00};
        vecs[8] = '{8'h00, 8'hA9, 8'h00, 8'h00, 2'b00, 8'h20, 8'hA6, 1'b1, 8'h08, 8'h5A};

        tick();
        tick();
        check("rst cb_q",   cb_q_o, 0);
        check("rst valid",  cb_q_valid_o, 0);
        check("rst d_o",    d_o, 0);
        check("rst ready",  d_ready_o, 1);
        check("rst busy",   cfg_busy_o, 0);
        check("rst in_sk",  in_skew_o, 3);
        check("rst out_sk", out_skew_o, 2);

        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            q_i       = {vecs[i].q1, vecs[i].q0};
            d_i       = {vecs[i].d1, vecs[i].d0};
            d_valid_i = vecs[i].dv;
            tick();
            check($sformatf("row%0d cb0", i),   cb_q_o[7:0],  vecs[i].e_cb0);
            check($sformatf("row%0d cb1", i),   cb_q_o[15:8], vecs[i].e_cb1);
            check($sformatf("row%0d valid", i), cb_q_valid_o, vecs[i].e_vld);
            check($sformatf("row%0d d0", i),    d_o[7:0],     vecs[i].e_d0);
            check($sformatf("row%0d d1", i),    d_o[15:8],    vecs[i].e_d1);
            check($sformatf("row%0d ready", i), d_ready_o,    1);
        end

        // Reconfigure to out skew 0 with two requests in flight
        idle();
        d_i[7:0] = 8'h11; d_valid_i = 2'b01;
        tick();
        check("rc a1 busy", cfg_busy_o, 0);
        d_i[7:0] = 8'h22; d_valid_i = 2'b01;
        cfg_we_i = 1'b1; in_skew_i = 3'd3; out_skew_i = 3'd0;
        tick();
        check("rc a2 busy",  cfg_busy_o, 1);
        check("rc a2 ready", d_ready_o, 0);
        check("rc a2 outsk", out_skew_o, 2);
        check("rc a2 d0",    d_o[7:0], 8'h08);
        idle();
        d_i[7:0] = 8'h33; d_valid_i = 2'b01;
        tick();
        check("rc a3 d0",    d_o[7:0], 8'h11);
        check("rc a3 busy",  cfg_busy_o, 1);
        check("rc a3 ready", d_ready_o, 0);
        d_i[7:0] = 8'h44; d_valid_i = 2'b01;
        tick();
        check("rc a4 d0",    d_o[7:0], 8'h22);
        check("rc a4 busy",  cfg_busy_o, 0);
        check("rc a4 ready", d_ready_o, 1);
        check("rc a4 outsk", out_skew_o, 0);
        d_i[7:0] = 8'h55; d_valid_i = 2'b01;
        tick();
        check("rc a5 d0",    d_o[7:0], 8'h55);
        idle();
        tick();
        check("rc a6 d0",    d_o[7:0], 8'h55);
        check("rc a6 d1",    d_o[15:8], 8'h5A);
        check("rc a6 valid", cb_q_valid_o, 1);

        // Clamp, then look-back of 0
        cfg_we_i = 1'b1; in_skew_i = 3'd7; out_skew_i = 3'd6; q_i[7:0] = 8'h11;
        tick();
        check("cl b1 in_sk",  in_skew_o, 3);
        check("cl b1 out_sk", out_skew_o, 4);
        cfg_we_i = 1'b1; in_skew_i = 3'd0; out_skew_i = 3'd4; q_i[7:0] = 8'h22;
        tick();
        check("cl b2 in_sk", in_skew_o, 0);
        check("cl b2 cb0",   cb_q_o[7:0], 8'h22);
        check("cl b2 valid", cb_q_valid_o, 1);
        cfg_we_i = 1'b0; q_i[7:0] = 8'h33;
        tick();
        check("cl b3 cb0",   cb_q_o[7:0], 8'h33);
        check("cl b3 valid", cb_q_valid_o, 1);

        // Last write wins during DRAIN
        idle();
        d_i[7:0] = 8'h77; d_valid_i = 2'b01;
        tick();
        idle();
        cfg_we_i = 1'b1; out_skew_i = 3'd1;
        tick();
        check("lw c2 busy", cfg_busy_o, 1);
        cfg_we_i = 1'b1; out_skew_i = 3'd4;
        tick();
        check("lw c3 busy", cfg_busy_o, 1);
        idle();
        tick();
        check("lw c4 busy", cfg_busy_o, 1);
        check("lw c4 d0",   d_o[7:0], 8'h55);
        tick();
        check("lw c5 d0",     d_o[7:0], 8'h77);
        check("lw c5 busy",   cfg_busy_o, 0);
        check("lw c5 out_sk", out_skew_o, 4);

        // Reset while draining
        d_i[7:0] = 8'h99; d_valid_i = 2'b01;
        tick();
        idle();
        cfg_we_i = 1'b1; out_skew_i = 3'd1;
        tick();
        check("rd d2 busy", cfg_busy_o, 1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd d_o",    d_o, 0);
        check("rd busy",   cfg_busy_o, 0);
        check("rd ready",  d_ready_o, 1);
        check("rd in_sk",  in_skew_o, 3);
        check("rd out_sk", out_skew_o, 2);
        check("rd valid",  cb_q_valid_o, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rd post%0d d_o", i), d_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
